lvds_tx_stream_arbiter: RTL and testbench
=========================================

// Module: lvds_tx_stream_arbiter
// PURPOSE
//  Shares the single LVDS TX serializer (lvds_tx) between two TX sample FIFOs (ch0, ch1).
//  Sits between the FIFOs and lvds_tx and looks to lvds_tx like one FIFO (empty/pull/data).
//  Grants round-robin in bursts and paces words by a programmable frame gap.
//  Reports the active channel and status to the control register block.
// PARAMETERS
//  BURST_LEN   16  words per grant before a switch is considered (2..255)
//  GAP_W       4   width of i_sample_gap
// PORTS
//  i_ddr_clk        in   1   LVDS DDR clock; sole clock
//  i_rst            in   1   synchronous, active-high reset
//  i_frame_sbe      in   1   1-cycle strobe per 32-bit LVDS frame boundary
//  i_ch_enable      in   2   per-channel enable, bit n = ch n
//  i_sample_gap     in   GAP_W  idle frames inserted after each forwarded word
//  i_ch0_empty      in   1   ch0 FIFO empty
//  o_ch0_pull       out  1   ch0 FIFO read pulse
//  i_ch0_data       in   32  ch0 FIFO head word
//  i_ch1_empty      in   1   ch1 FIFO empty
//  o_ch1_pull       out  1   ch1 FIFO read pulse
//  i_ch1_data       in   32  ch1 FIFO head word
//  o_fifo_empty     out  1   virtual-FIFO empty toward lvds_tx
//  i_fifo_pull      in   1   pull pulse from lvds_tx
//  o_fifo_data      out  32  virtual-FIFO data toward lvds_tx
//  o_active_ch      out  1   currently granted channel
//  o_busy           out  1   1 while in ST_STREAM
//  o_underrun_cnt   out  16  underrun count (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state ST_IDLE, grant=ch0, o_ch*_pull=0, o_fifo_empty=1, o_active_ch=0, o_busy=0,
//   counters 0. Reset mid-burst aborts immediately; no pull issued in the reset cycle.
//  States: ST_IDLE -> ST_STREAM when a channel is enabled and non-empty (pick ch != last grant
//   if both eligible, else the eligible one; 1 cycle). ST_STREAM -> ST_SWITCH when word_cnt==BURST_LEN,
//   or granted ch empty, or granted ch disabled. ST_SWITCH -> ST_STREAM(other ch) if eligible,
//   ST_STREAM(same ch, word_cnt=0) if only it is eligible, else ST_IDLE.
//  Grant hold rule: grant and o_fifo_data mux never change in a cycle with i_fifo_pull=1 or the cycle
//   after (lvds_tx samples data one cycle after pull). Leaving ST_STREAM is deferred accordingly.
//  Forwarding: o_chN_pull = i_fifo_pull & (grant==N) & (state==ST_STREAM), combinational, 0 latency.
//   o_fifo_data = granted ch data, combinational mux.
//  o_fifo_empty = 1 unless state==ST_STREAM, granted ch enabled & non-empty, gap_cnt==0,
//   word_cnt<BURST_LEN.
//  Pull while o_fifo_empty=1 is ignored (no upstream pull, no count).
//  word_cnt: +1 per forwarded pull; 8-bit, cleared on each grant; never exceeds BURST_LEN.
//  gap_cnt: loaded with i_sample_gap on each forwarded pull, -1 per i_frame_sbe, saturates at 0;
//   pull and i_frame_sbe in same cycle -> load wins. i_sample_gap=0 -> no pacing.
//  Underrun: in ST_STREAM, granted ch enabled, word_cnt<BURST_LEN, gap_cnt==0, ch empty on i_frame_sbe.
// CONFIGURATION
//  ARB_UNDERRUN_CNT_EN defined: 16-bit counter +1 per underrun event, saturates at 16'hFFFF,
//   cleared only by i_rst. Undefined: counter not built, o_underrun_cnt tied to 16'd0.
// STRUCTURE
//  Shared include lvds_tx_defs.vh: ST_IDLE/ST_STREAM/ST_SWITCH encodings (one-hot, 3 bit),
//   frame-width constant 32, zero_frame constant; reused by lvds_tx.
//  Sub-module lvds_tx_gap_pacer: gap_cnt load/decrement/zero flag (i_ddr_clk, i_rst).
// TESTING
//  1 Only ch0 enabled, 40 words, gap 0 -> 40 ch0 pulls, grant stays ch0, bursts of 16/16/8, ch1_pull never.
//  2 Both enabled, 64 words each, BURST_LEN=16 -> grant alternates 0,1,0,1... every 16 pulls; data order kept.
//  3 gap=3, ch0 full -> after each pull o_fifo_empty=1 for exactly 3 i_frame_sbe, then 0.
//  4 Pull in cycle k then burst end -> grant change no earlier than k+2; o_fifo_data stable at k+1.
//  5 ch1 empties mid-burst (word 5), ch0 non-empty -> switch to ch0; underrun_cnt +1 per empty frame
//    strobe before the switch only with ARB_UNDERRUN_CNT_EN, else 0.
//  6 i_rst high mid-burst -> next cycle all outputs at reset values; resumes from ST_IDLE on ch0 first.

Source files
------------

// File: rtl/lvds_tx_stream_arbiter_pkg.sv
// Shared types and constants for the LVDS TX stream arbiter and lvds_tx.
// State encodings are one-hot; the frame width matches the LVDS serializer word.
package lvds_tx_stream_arbiter_pkg;

   localparam int FRAME_W = 32;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'b001,
      ST_STREAM = 3'b010,
      ST_SWITCH = 3'b100
   } arb_state_e;

   // Channel to grant from IDLE: the preferred one when both are eligible, else the eligible one.
   function automatic logic pick_ch(input logic [1:0] elig, input logic pref);
      return (&elig) ? pref : elig[1];
   endfunction

endpackage

// File: rtl/lvds_tx_stream_arbiter_if.sv
// FIFO-side handshake bundle: two upstream sample FIFOs and the virtual FIFO toward lvds_tx.
// master = arbiter view, slave = FIFOs/lvds_tx view.
interface lvds_tx_stream_arbiter_if;
   import lvds_tx_stream_arbiter_pkg::*;

   logic               ch0_empty;
   logic               ch0_pull;
   logic [FRAME_W-1:0] ch0_data;
   logic               ch1_empty;
   logic               ch1_pull;
   logic [FRAME_W-1:0] ch1_data;
   logic               fifo_empty;
   logic               fifo_pull;
   logic [FRAME_W-1:0] fifo_data;

   modport master (
      input  ch0_empty, ch0_data, ch1_empty, ch1_data, fifo_pull,
      output ch0_pull, ch1_pull, fifo_empty, fifo_data
   );

   modport slave (
      output ch0_empty, ch0_data, ch1_empty, ch1_data, fifo_pull,
      input  ch0_pull, ch1_pull, fifo_empty, fifo_data
   );

endinterface

// File: rtl/lvds_tx_gap_pacer.sv
// Frame-gap pacer: counts idle LVDS frames after each forwarded word.
// A load on the same cycle as a frame strobe takes priority; the count saturates at zero.
module lvds_tx_gap_pacer #(
   parameter int GAP_W = 4
) (
   input  logic             i_ddr_clk,
   input  logic             i_rst,
   input  logic             i_load,
   input  logic             i_frame_sbe,
   input  logic [GAP_W-1:0] i_sample_gap,
   output logic             o_gap_zero
);

   logic [GAP_W-1:0] gap_cnt;

   // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_ddr_clk) begin
      if (i_rst) begin
         gap_cnt <= '0;
      end else if (i_load) begin
         gap_cnt <= i_sample_gap;
      end else if (i_frame_sbe && (gap_cnt != '0)) begin
         gap_cnt <= gap_cnt - 1'b1;
      end
   end

   assign o_gap_zero = (gap_cnt == '0);

endmodule

// File: rtl/lvds_tx_stream_arbiter.sv
// Round-robin burst arbiter presenting two TX sample FIFOs to lvds_tx as one FIFO.
// Optional feature: define ARB_UNDERRUN_CNT_EN to build the saturating underrun counter.
module lvds_tx_stream_arbiter
   import lvds_tx_stream_arbiter_pkg::*;
#(
   parameter int BURST_LEN = 16,
   parameter int GAP_W     = 4
) (
   input  logic                       i_ddr_clk,
   input  logic                       i_rst,
   input  logic                       i_frame_sbe,
   input  logic [1:0]                 i_ch_enable,
   input  logic [GAP_W-1:0]           i_sample_gap,
   lvds_tx_stream_arbiter_if.master   bus,
   output logic                       o_active_ch,
   output logic                       o_busy,
   output logic [15:0]                o_underrun_cnt
);

   localparam logic [7:0] BURST_MAX = 8'(BURST_LEN);

   arb_state_e state, state_nxt;
   logic       grant, grant_nxt;
   logic       pref, pref_nxt;   // channel favoured when both are eligible in IDLE
   logic       clr_cnt;
   logic [7:0] word_cnt;
   logic       pull_d;
   logic       gap_zero;
   logic [1:0] ch_empty, elig;
   logic       g_en, g_empty, streaming, burst_done, can_fwd, fwd, hold;

   assign ch_empty   = {bus.ch1_empty, bus.ch0_empty};
   assign elig       = i_ch_enable & ~ch_empty;
   assign g_en       = i_ch_enable[grant];
   assign g_empty    = ch_empty[grant];
   assign streaming  = (state == ST_STREAM);
   assign burst_done = (word_cnt >= BURST_MAX);
   assign can_fwd    = streaming & g_en & ~g_empty & gap_zero & ~burst_done & ~i_rst;
   assign fwd        = bus.fifo_pull & can_fwd;
   // lvds_tx samples data the cycle after a pull, so the mux is frozen for two cycles.
   assign hold       = bus.fifo_pull | pull_d;

   assign bus.fifo_empty = ~can_fwd;
   assign bus.ch0_pull   = fwd & ~grant;
   assign bus.ch1_pull   = fwd & grant;
   assign bus.fifo_data  = grant ? bus.ch1_data : bus.ch0_data;
   assign o_active_ch    = grant;
   assign o_busy         = streaming;

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      grant_nxt = grant;
      pref_nxt  = pref;
      clr_cnt   = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if ((|elig) && !hold) begin
               state_nxt = ST_STREAM;
               grant_nxt = pick_ch(elig, pref);
               clr_cnt   = 1'b1;
            end
         end
         ST_STREAM: begin
            if (!hold && (burst_done || g_empty || !g_en)) state_nxt = ST_SWITCH;
         end
         ST_SWITCH: begin
            if (!hold) begin
               if (elig[~grant]) begin
                  state_nxt = ST_STREAM;
                  grant_nxt = ~grant;
                  clr_cnt   = 1'b1;
               end else if (elig[grant]) begin
                  state_nxt = ST_STREAM;
                  clr_cnt   = 1'b1;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
      if (clr_cnt) pref_nxt = ~grant_nxt;
   end

   always_ff @(posedge i_ddr_clk) begin
      if (i_rst) begin
         state    <= ST_IDLE;
         grant    <= 1'b0;
         pref     <= 1'b0;
         word_cnt <= '0;
         pull_d   <= 1'b0;
      end else begin
         state    <= state_nxt;
         grant    <= grant_nxt;
         pref     <= pref_nxt;
         pull_d   <= bus.fifo_pull;
         if (clr_cnt) begin
            word_cnt <= '0;
         end else if (fwd) begin
            word_cnt <= word_cnt + 8'd1;
         end
      end
   end

   lvds_tx_gap_pacer #(.GAP_W(GAP_W)) u_gap_pacer (
      .i_ddr_clk    (i_ddr_clk),
      .i_rst        (i_rst),
      .i_load       (fwd),
      .i_frame_sbe  (i_frame_sbe),
      .i_sample_gap (i_sample_gap),
      .o_gap_zero   (gap_zero)
   );

`ifdef ARB_UNDERRUN_CNT_EN
   logic [15:0] underrun_cnt;
   logic        underrun;

   // A frame boundary passed while lvds_tx was entitled to a word but the granted FIFO had none.
   assign underrun = streaming & g_en & ~burst_done & gap_zero & g_empty & i_frame_sbe;

   always_ff @(posedge i_ddr_clk) begin
      if (i_rst) begin
         underrun_cnt <= '0;
      end else if (underrun && (underrun_cnt != 16'hFFFF)) begin
         underrun_cnt <= underrun_cnt + 16'd1;
      end
   end

   assign o_underrun_cnt = underrun_cnt;
`else
   assign o_underrun_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_lvds_tx_stream_arbiter.sv
// Self-checking bench for lvds_tx_stream_arbiter: scenario table plus directed corner sequences.
// Models both upstream FIFOs as word counters and acts as lvds_tx, pulling whenever data is offered.
module tb_lvds_tx_stream_arbiter;

   localparam int BURST_LEN = 16;
   localparam int GAP_W     = 4;
   localparam logic [31:0] BASE0 = 32'hA000_0000;
   localparam logic [31:0] BASE1 = 32'hB000_0000;
`ifdef ARB_UNDERRUN_CNT_EN
   localparam int EXP_UR = 2;
`else
   localparam int EXP_UR = 0;
`endif

   typedef struct {
      logic [1:0] en;
      int         n0, n1, gap, sbe_per;
      bit         alt;
      int         fix_len, exp_p0, exp_p1, exp_nb, exp_last, exp_first;
   } scn_t;

   logic             i_ddr_clk = 1'b0;
   logic             i_rst;
   logic             i_frame_sbe;
   logic [1:0]       i_ch_enable;
   logic [GAP_W-1:0] i_sample_gap;
   logic             o_active_ch, o_busy;
   logic [15:0]      o_underrun_cnt;

   lvds_tx_stream_arbiter_if bus ();

   lvds_tx_stream_arbiter #(.BURST_LEN(BURST_LEN), .GAP_W(GAP_W)) dut (
      .i_ddr_clk      (i_ddr_clk),
      .i_rst          (i_rst),
      .i_frame_sbe    (i_frame_sbe),
      .i_ch_enable    (i_ch_enable),
      .i_sample_gap   (i_sample_gap),
      .bus            (bus.master),
      .o_active_ch    (o_active_ch),
      .o_busy         (o_busy),
      .o_underrun_cnt (o_underrun_cnt)
   );

   always #5 i_ddr_clk = ~i_ddr_clk;

   int n_total = 0;
   int n_bad   = 0;
   int q0_left, q1_left, q0_idx, q1_idx;
   logic s_pull0, s_pull1, s_active, s_busy, s_empty, s_sbe;
   logic [31:0] s_data;
   logic [15:0] s_ur;
   bit   pull_age1, pull_age2;
   logic pull_active;
   scn_t scns[6];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic apply_fifos();
      bus.ch0_empty = (q0_left == 0);
      bus.ch1_empty = (q1_left == 0);
      bus.ch0_data  = BASE0 + 32'(q0_idx);
      bus.ch1_data  = BASE1 + 32'(q1_idx);
   endtask

   task automatic do_reset();
      i_rst = 1'b1;
      bus.fifo_pull = 1'b0;
      i_ch_enable = 2'b00;
      i_frame_sbe = 1'b0;
      i_sample_gap = '0;
      q0_left = 0; q1_left = 0; q0_idx = 0; q1_idx = 0;
      apply_fifos();
      repeat (2) @(posedge i_ddr_clk);
      #1;
      i_rst = 1'b0;
      pull_age1 = 1'b0;
      pull_age2 = 1'b0;
   endtask

   // One clock cycle: entered and left at posedge+1.
   task automatic step(input bit want_pull);
      apply_fifos();
      #1;
      bus.fifo_pull = want_pull & ~bus.fifo_empty;
      #1;
      s_pull0 = bus.ch0_pull; s_pull1 = bus.ch1_pull; s_data = bus.fifo_data;
      s_active = o_active_ch; s_busy = o_busy; s_empty = bus.fifo_empty;
      s_sbe = i_frame_sbe; s_ur = o_underrun_cnt;
      if (s_pull0) check("data_ch0", s_data, BASE0 + 32'(q0_idx));
      if (s_pull1) check("data_ch1", s_data, BASE1 + 32'(q1_idx));
      if (s_pull0 | s_pull1) check("pull_vs_active", s_active, s_pull1);
      if (pull_age1) check("hold_k1", s_active, pull_active);
      if (pull_age2) check("hold_k2", s_active, pull_active);
      pull_age2 = pull_age1;
      pull_age1 = s_pull0 | s_pull1;
      if (pull_age1) pull_active = s_active;
      @(posedge i_ddr_clk);
      if (s_pull0) begin q0_left--; q0_idx++; end
      if (s_pull1) begin q1_left--; q1_idx++; end
      #1;
      bus.fifo_pull = 1'b0;
   endtask

   task automatic run_scn(input int id, input scn_t s);
      int p0, p1, nb, cur, last_len, first_ch, cur_ch, prev_ch, idle, cyc;
      bit prev_busy;
      do_reset();
      q0_left = s.n0; q1_left = s.n1;
      i_ch_enable = s.en;
      i_sample_gap = GAP_W'(s.gap);
      p0 = 0; p1 = 0; nb = 0; cur = 0; last_len = 0; first_ch = -1;
      cur_ch = 0; prev_ch = 0; idle = 0; cyc = 0; prev_busy = 1'b0;
      while (idle < 40 && cyc < 3000) begin
         i_frame_sbe = (s.sbe_per != 0) && ((cyc % ((s.sbe_per != 0) ? s.sbe_per : 1)) == 0);
         step(1'b1);
         if (s_pull0) p0++;
         if (s_pull1) p1++;
         if (s_pull0 | s_pull1) begin
            if (first_ch < 0) first_ch = int'(s_pull1);
            cur_ch = int'(s_pull1);
            cur++;
         end
         if (prev_busy && !s_busy && cur > 0) begin
            nb++;
            check($sformatf("s%0d_burst_max", id), cur <= BURST_LEN, 1);
            if (s.fix_len != 0) check($sformatf("s%0d_burst_len", id), cur, s.fix_len);
            if (s.alt && nb > 1) check($sformatf("s%0d_alternate", id), cur_ch, prev_ch ^ 1);
            prev_ch = cur_ch;
            last_len = cur;
            cur = 0;
         end
         prev_busy = s_busy;
         idle = s_busy ? 0 : idle + 1;
         cyc++;
      end
      i_frame_sbe = 1'b0;
      check($sformatf("s%0d_timeout", id), cyc < 3000, 1);
      check($sformatf("s%0d_ch0_pulls", id), p0, s.exp_p0);
      check($sformatf("s%0d_ch1_pulls", id), p1, s.exp_p1);
      check($sformatf("s%0d_bursts", id), nb, s.exp_nb);
      check($sformatf("s%0d_last_len", id), last_len, s.exp_last);
      check($sformatf("s%0d_first_ch", id), first_ch, s.exp_first);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int pulls, sbe_cnt, n1seen, sbe_per;
      bit got;

      // en, n0, n1, gap, sbe_per, alt, fix_len, exp_p0, exp_p1, exp_nb, exp_last, exp_first
      scns[0] = '{2'b01, 40,  0, 0, 0, 1'b0,  0, 40,  0, 3,  8,  0};
      scns[1] = '{2'b11, 64, 64, 0, 0, 1'b1, 16, 64, 64, 8, 16,  0};
      scns[2] = '{2'b10, 10, 20, 0, 0, 1'b0,  0,  0, 20, 2,  4,  1};
      scns[3] = '{2'b11,  3,  3, 2, 3, 1'b1,  0,  3,  3, 2,  3,  0};
      scns[4] = '{2'b00,  5,  5, 0, 0, 1'b0,  0,  0,  0, 0,  0, -1};
      scns[5] = '{2'b11, 16,  0, 0, 0, 1'b0,  0, 16,  0, 1, 16,  0};

      // Reset state
      do_reset();
      #1;
      check("rst_fifo_empty", bus.fifo_empty, 1'b1);
      check("rst_busy", o_busy, 1'b0);
      check("rst_active", o_active_ch, 1'b0);
      check("rst_pulls", {bus.ch1_pull, bus.ch0_pull}, 2'b00);
      check("rst_underrun", o_underrun_cnt, 16'd0);
      @(posedge i_ddr_clk);
      #1;

      for (int i = 0; i < 6; i++) run_scn(i, scns[i]);

      // Gap pacing: exactly i_sample_gap empty frame strobes between forwarded words,
      // including the pull/strobe collision case (strobe every cycle).
      for (int k = 0; k < 2; k++) begin
         sbe_per = (k == 0) ? 4 : 1;
         do_reset();
         q0_left = 6;
         i_ch_enable = 2'b01;
         i_sample_gap = 4'd3;
         pulls = 0; sbe_cnt = 0;
         for (int c = 0; c < 400 && pulls < 5; c++) begin
            i_frame_sbe = ((c % sbe_per) == 0);
            step(1'b1);
            if (s_pull0) begin
               if (pulls > 0) check($sformatf("gap_sbe_cnt_p%0d", sbe_per), sbe_cnt, 3);
               pulls++;
               sbe_cnt = 0;
            end else if (pulls > 0 && s_empty && s_sbe) begin
               sbe_cnt++;
            end
         end
         i_frame_sbe = 1'b0;
         check($sformatf("gap_pulls_p%0d", sbe_per), pulls, 5);
      end

      // ch1 runs dry after 5 words while ch0 waits; frame strobes every cycle.
      do_reset();
      i_ch_enable = 2'b11;
      q1_left = 5;
      i_frame_sbe = 1'b1;
      got = 1'b0;
      n1seen = 0;
      for (int c = 0; c < 200 && !got; c++) begin
         step(1'b1);
         if (s_pull1) begin
            if (n1seen == 0) q0_left = 4;
            n1seen++;
         end
         if (n1seen > 0 && s_busy && !s_active) begin
            got = 1'b1;
            check("dry_ch1_words", n1seen, 5);
            check("dry_underrun", s_ur, EXP_UR);
            check("dry_ch0_pull", s_pull0, 1'b1);
            check("dry_ch0_data", s_data, BASE0);
         end
      end
      i_frame_sbe = 1'b0;
      check("dry_switch_seen", got, 1'b1);

      // Reset in the middle of a ch1 burst.
      do_reset();
      i_ch_enable = 2'b11;
      q0_left = 40; q1_left = 40;
      n1seen = 0;
      for (int c = 0; c < 200 && n1seen < 3; c++) begin
         step(1'b1);
         if (s_pull1) n1seen++;
      end
      check("mid_rst_in_ch1", n1seen, 3);
      apply_fifos();
      i_rst = 1'b1;
      bus.fifo_pull = 1'b1;
      #2;
      check("mid_rst_no_pull", {bus.ch1_pull, bus.ch0_pull}, 2'b00);
      @(posedge i_ddr_clk);
      #1;
      i_rst = 1'b0;
      bus.fifo_pull = 1'b0;
      pull_age1 = 1'b0;
      pull_age2 = 1'b0;
      #1;
      check("mid_rst_empty", bus.fifo_empty, 1'b1);
      check("mid_rst_busy", o_busy, 1'b0);
      check("mid_rst_active", o_active_ch, 1'b0);
      got = 1'b0;
      for (int c = 0; c < 50 && !got; c++) begin
         step(1'b1);
         if (s_pull0 | s_pull1) begin
            got = 1'b1;
            check("resume_ch0_first", s_pull0, 1'b1);
         end
      end
      check("resume_seen", got, 1'b1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
